// File: rtl/ysyx_24100029_pkg.sv
// Shared constants for the ysyx_24100029 fetch path: FSM encodings, AXI
// size/burst/response codes and the fetch base address.
package ysyx_24100029_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_MISS_AR = 3'd2;
  localparam logic [2:0] S_MISS_R  = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [31:0] ResetValue = 32'h3000_0000;

  typedef logic [1:0] axi_resp_t;

endpackage

// File: rtl/ysyx_24100029_icache_array.sv
// Direct-mapped tag/valid/data storage: synchronous writes, combinational reads.
// Only the valid bits are reset; tag and data contents are don't-care until validated.
module ysyx_24100029_icache_array #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(LINES),
  parameter int WORD_W     = $clog2(LINE_WORDS),
  parameter int TAG_W      = 32 - 2 - IDX_W - WORD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inv_all,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WORD_W-1:0] rd_word,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  input  logic              data_we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [31:0]       wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              wr_valid
);

  logic [31:0]      data_mem [LINES*LINE_WORDS];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_reg;

  always_ff @(posedge clock) begin
    if (data_we) data_mem[{wr_idx, wr_word}] <= wr_data;
    if (tag_we)  tag_mem[wr_idx] <= wr_tag;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      valid_reg <= '0;
    else if (inv_all) valid_reg <= '0;
    else if (tag_we)  valid_reg[wr_idx] <= wr_valid;
  end

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid_reg[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_word}];

endmodule

// File: rtl/ysyx_24100029_icache.sv
// Blocking direct-mapped instruction cache: single-word AXI fetch port in,
// whole-line INCR refill bursts out. Bus errors are returned and never cached.
module ysyx_24100029_icache
  import ysyx_24100029_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fence_i,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [3:0]  s_arid,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic [3:0]  s_rid,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arid,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic [3:0]  m_rid
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int TAG_W  = 32 - 2 - IDX_W - WORD_W;

  logic [2:0]        state_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       rdata_reg;
  logic [WORD_W-1:0] beat_reg;
  axi_resp_t         err_reg;
  axi_resp_t         rresp_reg;
  logic              fence_pending_reg;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              hit;
  logic              fill_beat;
  logic              fill_last;
  logic              inv_all;
  axi_resp_t         fill_resp;

  assign req_tag  = addr_reg[31 -: TAG_W];
  assign req_idx  = addr_reg[2+WORD_W +: IDX_W];
  assign req_word = addr_reg[2 +: WORD_W];

  assign hit       = rd_valid && (rd_tag == req_tag);
  assign fill_beat = (state_reg == S_MISS_R) && m_rvalid;
  assign fill_last = fill_beat && m_rlast;
  // First nonzero response of the burst sticks, including the current beat.
  assign fill_resp = (err_reg != AXI_RESP_OKAY) ? err_reg : m_rresp;
  assign inv_all   = (state_reg == S_IDLE) && (fence_i || fence_pending_reg);

  assign s_arready = (state_reg == S_IDLE) && !fence_pending_reg;
  assign s_rvalid  = (state_reg == S_RESP);
  assign s_rdata   = rdata_reg;
  assign s_rresp   = rresp_reg;
  assign s_rlast   = 1'b1;
  assign s_rid     = 4'd0;

  assign m_arvalid = (state_reg == S_MISS_AR);
  assign m_araddr  = {addr_reg[31:2+WORD_W], {(WORD_W+2){1'b0}}};
  assign m_arid    = 4'd0;
  assign m_arlen   = 8'(LINE_WORDS - 1);
  assign m_arsize  = AXI_SIZE_4B;
  assign m_arburst = AXI_BURST_INCR;
  assign m_rready  = (state_reg == S_MISS_R);

  logic unused_inputs;
  assign unused_inputs = ^{s_arid, s_arlen, s_arsize, s_arburst, m_rid, addr_reg[1:0]};

  ysyx_24100029_icache_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .inv_all  (inv_all),
    .rd_idx   (req_idx),
    .rd_word  (req_word),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .data_we  (fill_beat),
    .wr_idx   (req_idx),
    .wr_word  (beat_reg),
    .wr_data  (m_rdata),
    .tag_we   (fill_last),
    .wr_tag   (req_tag),
    .wr_valid (fill_resp == AXI_RESP_OKAY)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg         <= S_IDLE;
      addr_reg          <= ResetValue;
      rdata_reg         <= '0;
      beat_reg          <= '0;
      err_reg           <= AXI_RESP_OKAY;
      rresp_reg         <= AXI_RESP_OKAY;
      fence_pending_reg <= 1'b0;
    end else begin
      // A fence seen while busy is deferred until the cache is idle again.
      if (state_reg == S_IDLE) fence_pending_reg <= 1'b0;
      else if (fence_i)        fence_pending_reg <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (s_arvalid && s_arready) begin
            addr_reg  <= s_araddr;
            state_reg <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            rdata_reg <= rd_data;
            rresp_reg <= AXI_RESP_OKAY;
            state_reg <= S_RESP;
          end else begin
            err_reg   <= AXI_RESP_OKAY;
            beat_reg  <= '0;
            state_reg <= S_MISS_AR;
          end
        end
        S_MISS_AR: begin
          if (m_arready) state_reg <= S_MISS_R;
        end
        S_MISS_R: begin
          if (m_rvalid) begin
            beat_reg <= beat_reg + 1'b1;
            err_reg  <= fill_resp;
            if (beat_reg == req_word) rdata_reg <= m_rdata;
            if (m_rlast) begin
              beat_reg  <= '0;
              rresp_reg <= fill_resp;
              state_reg <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (s_rready) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_icache.sv
// Scoreboard bench for the instruction cache: a line-fill bus model answers
// refills, expected fetch results are queued at issue and popped on R handshake.
module tb_ysyx_24100029_icache;

  logic        clock;
  logic        reset;
  logic        fence_i;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [3:0]  s_rid;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          ar_count = 0;
  int          err_beat = -1;
  logic [1:0]  err_val = 2'b00;
  logic [31:0] exp_line = 32'h0;

  ysyx_24100029_icache dut (
    .clock     (clock),
    .reset     (reset),
    .fence_i   (fence_i),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_araddr  (s_araddr),
    .s_arid    (4'd0),
    .s_arlen   (8'd0),
    .s_arsize  (3'b010),
    .s_arburst (2'b01),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .s_rid     (s_rid),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_araddr  (m_araddr),
    .m_arid    (m_arid),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arburst (m_arburst),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_rid     (4'd0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h3000000) begin
      case (a[3:2])
        2'd0:    return 32'h11;
        2'd1:    return 32'h22;
        2'd2:    return 32'h33;
        default: return 32'h44;
      endcase
    end
    return {a[15:0], ~a[15:0]};
  endfunction

  // Refill slave: one AR, then four beats with occasional idle gaps.
  initial begin
    logic [31:0] line;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = 32'h0;
    m_rresp   = 2'b00;
    m_rlast   = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && m_arvalid) begin
        line = m_araddr;
        check("m_araddr", m_araddr, exp_line);
        check("m_arlen", {24'h0, m_arlen}, 32'd3);
        check("m_arsize_burst", {27'h0, m_arsize, m_arburst}, {27'h0, 3'b010, 2'b01});
        @(posedge clock); #1 m_arready = 1'b1;
        @(posedge clock); #1 m_arready = 1'b0;
        ar_count++;
        for (int i = 0; i < 4; i++) begin
          m_rvalid = 1'b1;
          m_rdata  = mem_word(line + 32'(4 * i));
          m_rresp  = (i == err_beat) ? err_val : 2'b00;
          m_rlast  = (i == 3);
          @(posedge clock); #1;
          m_rvalid = 1'b0;
          m_rlast  = 1'b0;
          m_rresp  = 2'b00;
          if ($urandom_range(0, 1) == 1) begin
            @(posedge clock); #1;
          end
        end
      end
    end
  end

  // Scoreboard consumer: one comparison pair per R handshake.
  always @(negedge clock) begin
    if (reset && s_rvalid && s_rready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("s_rdata", s_rdata, e.data);
        check("s_rresp", {30'h0, s_rresp}, {30'h0, e.resp});
        $display("fetch done: rdata=0x%08h rresp=%0d", s_rdata, s_rresp);
      end
    end
  end

  task automatic fetch(input logic [31:0] addr, input bit exp_miss, input int stall);
    exp_t e;
    int   ar0;
    int   hs;
    int   t;
    e.data   = mem_word(addr);
    e.resp   = (exp_miss && err_beat >= 0) ? err_val : 2'b00;
    exp_line = {addr[31:4], 4'h0};
    ar0      = ar_count;
    sb_q.push_back(e);
    @(posedge clock); #1;
    s_arvalid = 1'b1;
    s_araddr  = addr;
    s_rready  = 1'b0;
    t = 0;
    @(negedge clock);
    while (!s_arready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!s_arready) begin
      check("ar_handshake_timeout", 32'd0, 32'd1);
      void'(sb_q.pop_back());
      @(posedge clock); #1 s_arvalid = 1'b0;
      return;
    end
    hs = cyc;
    @(posedge clock); #1 s_arvalid = 1'b0;
    t = 0;
    @(negedge clock);
    while (!s_rvalid && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!s_rvalid) begin
      check("rvalid_timeout", 32'd0, 32'd1);
      void'(sb_q.pop_back());
      return;
    end
    if (!exp_miss) check("hit_latency", 32'(cyc - hs), 32'd2);
    check("refill_count", 32'(ar_count - ar0), {31'h0, exp_miss});
    for (int k = 0; k < stall; k++) begin
      @(negedge clock);
      check("stall_rvalid", {31'h0, s_rvalid}, 32'd1);
      check("stall_rdata", s_rdata, e.data);
      check("stall_arready", {31'h0, s_arready}, 32'd0);
    end
    @(posedge clock); #1 s_rready = 1'b1;
    @(posedge clock); #1 s_rready = 1'b0;
  endtask

  task automatic fence_during_fill();
    int t = 0;
    @(negedge clock);
    while (!m_rready && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("fence_fill_in_miss_r", {31'h0, m_rready}, 32'd1);
    @(posedge clock); #1 fence_i = 1'b1;
    @(posedge clock); #1 fence_i = 1'b0;
  endtask

  task automatic reset_mid_fill();
    int t = 0;
    exp_line = 32'h3000_0040;
    @(posedge clock); #1;
    s_arvalid = 1'b1;
    s_araddr  = 32'h3000_0044;
    @(negedge clock);
    while (!s_arready && t < 50) begin
      @(negedge clock);
      t++;
    end
    @(posedge clock); #1 s_arvalid = 1'b0;
    t = 0;
    @(negedge clock);
    while (!m_rready && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("rst_fill_in_miss_r", {31'h0, m_rready}, 32'd1);
    @(posedge clock); #1 reset = 1'b0;
    #1;
    check("rst_mid_m_arvalid", {31'h0, m_arvalid}, 32'd0);
    check("rst_mid_m_rready", {31'h0, m_rready}, 32'd0);
    check("rst_mid_s_rvalid", {31'h0, s_rvalid}, 32'd0);
    check("rst_mid_s_rdata", s_rdata, 32'd0);
    check("rst_mid_s_arready", {31'h0, s_arready}, 32'd1);
    @(posedge clock); #1 reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    fence_i   = 1'b0;
    s_arvalid = 1'b0;
    s_araddr  = 32'h0;
    s_rready  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_s_arready", {31'h0, s_arready}, 32'd1);
    check("rst_s_rvalid", {31'h0, s_rvalid}, 32'd0);
    check("rst_m_arvalid", {31'h0, m_arvalid}, 32'd0);
    check("rst_m_rready", {31'h0, m_rready}, 32'd0);
    check("rst_s_rdata", s_rdata, 32'd0);
    check("rst_s_rresp", {30'h0, s_rresp}, 32'd0);
    check("rst_rlast_rid", {27'h0, s_rlast, s_rid}, {27'h0, 1'b1, 4'd0});
    reset = 1'b1;

    fetch(32'h3000_0004, 1'b1, 0);
    fetch(32'h3000_000C, 1'b0, 0);
    fetch(32'h3000_0100, 1'b1, 0);
    fetch(32'h3000_0000, 1'b1, 0);
    fetch(32'h3000_0008, 1'b0, 0);

    err_beat = 2;
    err_val  = 2'b10;
    fetch(32'h3000_0020, 1'b1, 0);
    err_beat = -1;
    fetch(32'h3000_0024, 1'b1, 0);
    fetch(32'h3000_0028, 1'b0, 0);

    fork
      fetch(32'h3000_0030, 1'b1, 0);
      fence_during_fill();
    join
    fetch(32'h3000_0034, 1'b1, 0);
    fetch(32'h3000_0038, 1'b0, 5);

    @(posedge clock); #1 fence_i = 1'b1;
    @(posedge clock); #1 fence_i = 1'b0;
    fetch(32'h3000_0030, 1'b1, 0);

    reset_mid_fill();
    fetch(32'h3000_0044, 1'b1, 0);
    fetch(32'h3000_0038, 1'b1, 0);

    repeat (5) @(posedge clock);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
